pu_da_dc_refill: RTL and testbench

// - DA-stage data-cache lookup/refill controller, directly downstream of the DTLB.
// - Registers the request index so it lines up with the DTLB's 1-cycle-late ptag/nc.
// - Holds a direct-mapped tag/valid array, produces hit and miss stall, runs a

---
 rtl/pu_da_dc_refill.sv | 166 ++++++++++++++++
 tb/tb_pu_da_dc_refill.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pu_da_dc_refill.sv
// DA-stage data-cache lookup and burst-refill controller (direct-mapped tag/valid array).
// Optional critical-word-first refill: define PU_DC_REFILL_CWF_EN.
module pu_da_dc_refill #(
  parameter int TAG_W  = 20,
  parameter int IDX_W  = 6,
  parameter int WORD_W = 2,
  parameter int DATA_W = 32
) (
  input  logic                            clk,
  input  logic                            rst_,
  input  logic                            req,
  input  logic [IDX_W-1:0]                idx,
  input  logic [WORD_W-1:0]               wofs,
  input  logic [TAG_W-1:0]                ptag,
  input  logic                            nc,
  input  logic                            inv,
  output logic                            hit,
  output logic                            miss_stall,
  output logic                            inv_busy,
  output logic                            bus_req,
  output logic [TAG_W+IDX_W+WORD_W-1:0]   bus_addr,
  output logic                            bus_len1,
  input  logic                            bus_gnt,
  input  logic                            bus_rdy,
  input  logic [DATA_W-1:0]               bus_rdata,
  output logic                            dw_en,
  output logic [IDX_W-1:0]                dw_idx,
  output logic [WORD_W-1:0]               dw_word,
  output logic [DATA_W-1:0]               dw_data,
  output logic                            nc_vld,
  output logic [DATA_W-1:0]               nc_data
);

  localparam int LINES = 1 << IDX_W;

  typedef enum logic [2:0] {IDLE, REQ, FILL, DONE, INV} state_t;

  state_t             state;
  logic               req_q;
  logic [IDX_W-1:0]   idx_q;
  logic [WORD_W-1:0]  wofs_q;
  logic [TAG_W-1:0]   tag_mem [LINES];
  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   ptag_l;
  logic               nc_l;
  logic [WORD_W-1:0]  beat;
  logic [WORD_W-1:0]  first_word;
  logic [IDX_W-1:0]   inv_cnt;
  logic               inv_pend;

  always_comb begin
    first_word = '0;
`ifdef PU_DC_REFILL_CWF_EN
    first_word = wofs_q;
`endif
  end

  assign hit = req_q & ~nc & valid[idx_q] & (tag_mem[idx_q] == ptag) & (state == IDLE);

  // Only an nc completion releases the pipeline directly; a cached fill releases via the re-lookup hit.
  always_comb begin
    miss_stall = 1'b1;
    case (state)
      IDLE:    miss_stall = req_q & ~hit;
      INV:     miss_stall = req_q;
      DONE:    miss_stall = ~nc_l;
      default: miss_stall = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == DONE && !nc_l)
      tag_mem[idx_q] <= ptag_l;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state    <= IDLE;
      req_q    <= 1'b0;
      idx_q    <= '0;
      wofs_q   <= '0;
      valid    <= '0;
      ptag_l   <= '0;
      nc_l     <= 1'b0;
      beat     <= '0;
      inv_cnt  <= '0;
      inv_pend <= 1'b0;
      inv_busy <= 1'b0;
      bus_req  <= 1'b0;
      bus_addr <= '0;
      bus_len1 <= 1'b0;
      dw_en    <= 1'b0;
      dw_idx   <= '0;
      dw_word  <= '0;
      dw_data  <= '0;
      nc_vld   <= 1'b0;
      nc_data  <= '0;
    end else begin
      dw_en  <= 1'b0;
      nc_vld <= 1'b0;
      if (!miss_stall) begin
        req_q  <= req;
        idx_q  <= idx;
        wofs_q <= wofs;
      end
      case (state)
        IDLE: begin
          if (req_q && !hit) begin
            state    <= REQ;
            ptag_l   <= ptag;
            nc_l     <= nc;
            bus_req  <= 1'b1;
            bus_len1 <= nc;
            bus_addr <= {ptag, idx_q, (nc ? wofs_q : first_word)};
            beat     <= '0;
            if (inv) inv_pend <= 1'b1;
          end else if (inv || inv_pend) begin
            state    <= INV;
            inv_pend <= 1'b0;
            inv_cnt  <= '0;
            inv_busy <= 1'b1;
          end
        end
        REQ: begin
          if (inv) inv_pend <= 1'b1;
          if (bus_gnt) begin
            bus_req <= 1'b0;
            state   <= FILL;
          end
        end
        FILL: begin
          if (inv) inv_pend <= 1'b1;
          if (bus_rdy) begin
            if (nc_l) begin
              nc_data <= bus_rdata;
              nc_vld  <= 1'b1;
              state   <= DONE;
            end else begin
              dw_en   <= 1'b1;
              dw_idx  <= idx_q;
              dw_word <= first_word + beat;
              dw_data <= bus_rdata;
              beat    <= beat + 1'b1;
              if (beat == '1) state <= DONE;
            end
          end
        end
        DONE: begin
          if (inv) inv_pend <= 1'b1;
          if (!nc_l) valid[idx_q] <= 1'b1;
          state <= IDLE;
        end
        INV: begin
          valid[inv_cnt] <= 1'b0;
          inv_cnt        <= inv_cnt + 1'b1;
          if (inv_cnt == '1) begin
            state    <= IDLE;
            inv_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pu_da_dc_refill.sv
// Self-checking bench for pu_da_dc_refill: directed steps plus randomized accesses
// against a line-level cache model (tag/valid arrays, expected bus and write sequences).
module tb_pu_da_dc_refill;

`ifdef PU_DC_REFILL_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic        req = 1'b0;
  logic [5:0]  idx = '0;
  logic [1:0]  wofs = '0;
  logic [19:0] ptag = '0;
  logic        nc = 1'b0;
  logic        inv = 1'b0;
  logic        hit, miss_stall, inv_busy, bus_req, bus_len1;
  logic [27:0] bus_addr;
  logic        bus_gnt = 1'b0;
  logic        bus_rdy = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        dw_en;
  logic [5:0]  dw_idx;
  logic [1:0]  dw_word;
  logic [31:0] dw_data;
  logic        nc_vld;
  logic [31:0] nc_data;

  int vectors = 0;
  int errors  = 0;

  bit          mvalid [64];
  logic [19:0] mtag   [64];
  logic [19:0] tpool  [3];

  pu_da_dc_refill #(.TAG_W(20), .IDX_W(6), .WORD_W(2), .DATA_W(32)) dut (
    .clk(clk), .rst_(rst_), .req(req), .idx(idx), .wofs(wofs), .ptag(ptag), .nc(nc),
    .inv(inv), .hit(hit), .miss_stall(miss_stall), .inv_busy(inv_busy),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_len1(bus_len1), .bus_gnt(bus_gnt),
    .bus_rdy(bus_rdy), .bus_rdata(bus_rdata), .dw_en(dw_en), .dw_idx(dw_idx),
    .dw_word(dw_word), .dw_data(dw_data), .nc_vld(nc_vld), .nc_data(nc_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tg, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tg, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 64; k++) mvalid[k] = 1'b0;
  endtask

  task automatic wait_sweep();
    int n;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      if (inv_busy) n++;
      else if (n > 0) break;
      @(negedge clk);
    end
    chk("inv_len", 64'(n), 64'(64));
    clear_model();
  endtask

  task automatic do_inv();
    @(negedge clk); inv = 1'b1;
    @(negedge clk); inv = 1'b0;
    wait_sweep();
  endtask

  task automatic access(input int i, input int w, input logic [19:0] t, input bit n,
                        input bit inv_mid, input int gdelay);
    bit          exp_hit;
    int          start, d, nb, gap;
    logic [31:0] dat;
    logic [27:0] ea;
    exp_hit = mvalid[i] && (mtag[i] == t) && !n;
    @(negedge clk);
    req = 1'b1; idx = 6'(i); wofs = 2'(w); ptag = t; nc = n;
    @(negedge clk);
    req = 1'b0;
    chk("hit", 64'(hit), 64'(exp_hit));
    chk("stall", 64'(miss_stall), 64'(!exp_hit));
    if (exp_hit) begin
      @(negedge clk);
      chk("no_bus_req", 64'(bus_req), 64'(0));
      return;
    end
    for (int g = 0; g < 5 && !bus_req; g++) @(negedge clk);
    chk("bus_req", 64'(bus_req), 64'(1));
    start = (n || CWF) ? w : 0;
    ea = {t, 6'(i), 2'(start)};
    chk("bus_addr", 64'(bus_addr), 64'(ea));
    chk("bus_len1", 64'(bus_len1), 64'(n));
    d = (gdelay < 0) ? int'($urandom_range(0, 4)) : gdelay;
    for (int k = 0; k < d; k++) begin
      bus_rdy = 1'($urandom);
      @(negedge clk);
      chk("req_hold", 64'(bus_req), 64'(1));
      chk("addr_hold", 64'(bus_addr), 64'(ea));
    end
    bus_gnt = 1'b1; bus_rdy = 1'($urandom);
    @(negedge clk);
    bus_gnt = 1'b0; bus_rdy = 1'b0;
    chk("req_drop", 64'(bus_req), 64'(0));
    nb = n ? 1 : 4;
    for (int b = 0; b < nb; b++) begin
      gap = int'($urandom_range(0, 2));
      for (int k = 0; k < gap; k++) begin
        @(negedge clk);
        chk("dw_idle", 64'(dw_en), 64'(0));
      end
      dat = $urandom;
      bus_rdy = 1'b1; bus_rdata = dat;
      if (inv_mid && b == 0) inv = 1'b1;
      @(negedge clk);
      bus_rdy = 1'b0; inv = 1'b0;
      if (n) begin
        chk("nc_vld", 64'(nc_vld), 64'(1));
        chk("nc_data", 64'(nc_data), 64'(dat));
        chk("nc_no_dw", 64'(dw_en), 64'(0));
        chk("nc_stall", 64'(miss_stall), 64'(0));
      end else begin
        chk("dw_en", 64'(dw_en), 64'(1));
        chk("dw_idx", 64'(dw_idx), 64'(i));
        chk("dw_word", 64'(dw_word), 64'((start + b) % 4));
        chk("dw_data", 64'(dw_data), 64'(dat));
      end
    end
    if (!n) begin
      chk("done_stall", 64'(miss_stall), 64'(1));
      @(negedge clk);
      chk("relookup_hit", 64'(hit), 64'(1));
      chk("relookup_stall", 64'(miss_stall), 64'(0));
      mvalid[i] = 1'b1;
      mtag[i]   = t;
    end else begin
      @(negedge clk);
      chk("nc_vld_pulse", 64'(nc_vld), 64'(0));
    end
    if (inv_mid) wait_sweep();
  endtask

  initial begin
    clear_model();
    tpool[0] = 20'h12345; tpool[1] = 20'h54321; tpool[2] = 20'hABCDE;
    repeat (3) @(negedge clk);
    chk("rst_hit", 64'(hit), 64'(0));
    chk("rst_stall", 64'(miss_stall), 64'(0));
    chk("rst_bus_req", 64'(bus_req), 64'(0));
    chk("rst_dw_en", 64'(dw_en), 64'(0));
    chk("rst_inv_busy", 64'(inv_busy), 64'(0));
    chk("rst_nc_vld", 64'(nc_vld), 64'(0));
    rst_ = 1'b1;

    access(5, 0, 20'h12345, 1'b0, 1'b0, -1);
    access(5, 1, 20'h12345, 1'b0, 1'b0, -1);
    access(5, 0, 20'h54321, 1'b0, 1'b0, -1);
    access(5, 3, 20'h54321, 1'b0, 1'b0, -1);
    access(3, 0, 20'hABCDE, 1'b0, 1'b0, -1);
    access(3, 2, 20'hABCDE, 1'b1, 1'b0, -1);
    access(3, 1, 20'hABCDE, 1'b0, 1'b0, -1);
    access(7, 0, 20'h11111, 1'b0, 1'b1, -1);
    access(5, 0, 20'h54321, 1'b0, 1'b0, 10);
    access(9, 2, 20'h0F0F0, 1'b0, 1'b0, -1);
    access(12, 1, 20'h33333, 1'b1, 1'b1, 2);

    // reset on the second beat of a cached refill
    @(negedge clk);
    req = 1'b1; idx = 6'd5; wofs = 2'd0; ptag = 20'h2468A; nc = 1'b0;
    @(negedge clk);
    req = 1'b0;
    chk("rb_stall", 64'(miss_stall), 64'(1));
    for (int g = 0; g < 5 && !bus_req; g++) @(negedge clk);
    chk("rb_bus_req", 64'(bus_req), 64'(1));
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0; bus_rdy = 1'b1; bus_rdata = 32'h1;
    @(negedge clk);
    bus_rdata = 32'h2;
    #1 rst_ = 1'b0;
    #1;
    chk("rb_bus_req_drop", 64'(bus_req), 64'(0));
    chk("rb_dw_en", 64'(dw_en), 64'(0));
    chk("rb_stall_drop", 64'(miss_stall), 64'(0));
    @(negedge clk);
    bus_rdy = 1'b0;
    rst_ = 1'b1;
    clear_model();
    access(5, 0, 20'h2468A, 1'b0, 1'b0, -1);
    access(5, 0, 20'h2468A, 1'b0, 1'b0, -1);

    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 9) == 0) do_inv();
      else access(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                  tpool[$urandom_range(0, 2)], ($urandom_range(0, 4) == 0), 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
